index_mask_accumulator: RTL and testbench

INDEX_MASK_ACCUMULATOR -- requirements
Module: index_mask_accumulator

---
 rtl/index_mask_accumulator.sv | 133 +++++++++++++
 tb/tb_index_mask_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/index_mask_accumulator.sv
// Accumulates a bitmask from a stream of index beats and presents it, with its popcount and flags, once per message.
// Optional duplicate-index detection is enabled by defining INDEX_MASK_ACCUMULATOR_DUP_DETECT_EN.
module index_mask_accumulator #(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idx_valid_i,
    output logic             idx_ready_o,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             idx_last_i,
    output logic             mask_valid_o,
    input  logic             mask_ready_i,
    output logic [WIDTH-1:0] mask_o,
    output logic [CNT_W-1:0] count_o,
    output logic             oor_o,
    output logic             dup_o
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [IDX_W:0]   WIDTH_L = (IDX_W + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_L   = {{(WIDTH - 1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(CNT_W - 1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             oor_acc_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] count_q;
    logic             oor_q;

    logic             hs_s;
    logic             in_range_s;
    logic [WIDTH-1:0] bit_s;
    logic [WIDTH-1:0] acc_d;
    logic             oor_acc_d;

    // Next accumulator contents for the beat currently offered.
    always_comb begin
        hs_s       = idx_valid_i && (state_q == ACCUM);
        in_range_s = ({1'b0, idx_i} < WIDTH_L);
        bit_s      = in_range_s ? (ONE_L << idx_i) : '0;
        acc_d      = acc_q | bit_s;
        oor_acc_d  = oor_acc_q | ~in_range_s;
    end

`ifdef INDEX_MASK_ACCUMULATOR_DUP_DETECT_EN
    logic dup_acc_q;
    logic dup_q;
    logic dup_acc_d;

    // A beat is a duplicate when its in-range bit is already present.
    always_comb begin
        dup_acc_d = dup_acc_q | (|(acc_q & bit_s));
    end

    // Duplicate tracking follows the same message lifecycle as the mask.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dup_acc_q <= 1'b0;
            dup_q     <= 1'b0;
        end else if (hs_s) begin
            dup_acc_q <= idx_last_i ? 1'b0 : dup_acc_d;
            dup_q     <= idx_last_i ? dup_acc_d : 1'b0;
        end else if (state_q == HOLD && mask_ready_i) begin
            dup_q     <= 1'b0;
        end else begin
            dup_q     <= dup_q;
        end
    end

    assign dup_o = dup_q;
`else
    assign dup_o = 1'b0;
`endif

    // Message FSM: accumulate beats, then latch results until the consumer takes them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            oor_acc_q <= 1'b0;
            mask_q    <= '0;
            count_q   <= '0;
            oor_q     <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (hs_s && idx_last_i) begin
                        mask_q    <= acc_d;
                        count_q   <= popcount(acc_d);
                        oor_q     <= oor_acc_d;
                        acc_q     <= '0;
                        oor_acc_q <= 1'b0;
                        state_q   <= HOLD;
                    end else if (hs_s) begin
                        acc_q     <= acc_d;
                        oor_acc_q <= oor_acc_d;
                    end
                end
                HOLD: begin
                    if (mask_ready_i) begin
                        mask_q  <= '0;
                        count_q <= '0;
                        oor_q   <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign idx_ready_o  = (state_q == ACCUM);
    assign mask_valid_o = (state_q == HOLD);
    assign mask_o       = mask_q;
    assign count_o      = count_q;
    assign oor_o        = oor_q;

endmodule

// File: tb/tb_index_mask_accumulator.sv
// Self-checking bench: WIDTH=8 and WIDTH=6 instances share one stimulus stream and are checked against a message-level model.
module tb_index_mask_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       idx_valid;
    logic [2:0] idx;
    logic       idx_last;
    logic       mask_ready;

    logic       rdy8, mv8, oor8, dup8;
    logic [7:0] mask8;
    logic [3:0] cnt8;
    logic       rdy6, mv6, oor6, dup6;
    logic [5:0] mask6;
    logic [2:0] cnt6;

    int vectors = 0;
    int miscompares = 0;
    int msg_q[$];

    always #5 clk = ~clk;

    index_mask_accumulator #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .idx_valid_i(idx_valid), .idx_ready_o(rdy8),
        .idx_i(idx), .idx_last_i(idx_last), .mask_valid_o(mv8), .mask_ready_i(mask_ready),
        .mask_o(mask8), .count_o(cnt8), .oor_o(oor8), .dup_o(dup8)
    );

    index_mask_accumulator #(.WIDTH(6)) dut6 (
        .clk_i(clk), .rst_i(rst), .idx_valid_i(idx_valid), .idx_ready_o(rdy6),
        .idx_i(idx), .idx_last_i(idx_last), .mask_valid_o(mv6), .mask_ready_i(mask_ready),
        .mask_o(mask6), .count_o(cnt6), .oor_o(oor6), .dup_o(dup6)
    );

    typedef struct {
        int         n;
        int         ids [4];
        logic [7:0] m8;
        int         c8;
        bit         o8;
        logic [5:0] m6;
        int         c6;
        bit         o6;
        bit         dup;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Message-level reference: plain set arithmetic over the queued indices.
    task automatic model(input int w, output logic [63:0] m, output int c, output bit o, output bit d);
        m = '0; o = 1'b0; d = 1'b0;
        foreach (msg_q[i]) begin
            if (msg_q[i] >= w) o = 1'b1;
            else begin
                if (m[msg_q[i]]) d = 1'b1;
                m[msg_q[i]] = 1'b1;
            end
        end
        c = $countones(m);
`ifndef INDEX_MASK_ACCUMULATOR_DUP_DETECT_EN
        d = 1'b0;
`endif
    endtask

    task automatic check_hold(input string tag);
        logic [63:0] m; int c; bit o, d;
        model(8, m, c, o, d);
        check({tag, " mv8"}, 64'(mv8), 64'd1);
        check({tag, " rdy8"}, 64'(rdy8), 64'd0);
        check({tag, " mask8"}, 64'(mask8), m);
        check({tag, " cnt8"}, 64'(cnt8), 64'(c));
        check({tag, " oor8"}, 64'(oor8), 64'(o));
        check({tag, " dup8"}, 64'(dup8), 64'(d));
        model(6, m, c, o, d);
        check({tag, " mv6"}, 64'(mv6), 64'd1);
        check({tag, " mask6"}, 64'(mask6), m);
        check({tag, " cnt6"}, 64'(cnt6), 64'(c));
        check({tag, " oor6"}, 64'(oor6), 64'(o));
        check({tag, " dup6"}, 64'(dup6), 64'(d));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle rdy8"}, 64'(rdy8), 64'd1);
        check({tag, " idle mv8"}, 64'(mv8), 64'd0);
        check({tag, " idle mask8"}, 64'(mask8), 64'd0);
        check({tag, " idle cnt8"}, 64'(cnt8), 64'd0);
        check({tag, " idle oor8"}, 64'(oor8), 64'd0);
        check({tag, " idle dup8"}, 64'(dup8), 64'd0);
        check({tag, " idle rdy6"}, 64'(rdy6), 64'd1);
        check({tag, " idle mask6"}, 64'(mask6), 64'd0);
    endtask

    // Sends msg_q as one message, holds the result for hold_cycles, then releases it.
    task automatic run_msg(input string tag, input int max_gap, input int hold_cycles, input bit ready_held);
        mask_ready = ready_held;
        foreach (msg_q[i]) begin
            repeat ($urandom_range(max_gap)) begin
                idx_valid = 1'b0; idx = 3'($urandom); idx_last = 1'($urandom);
                tick();
            end
            idx_valid = 1'b1; idx = 3'(msg_q[i]); idx_last = (i == msg_q.size() - 1);
            check({tag, " beat rdy8"}, 64'(rdy8), 64'd1);
            check({tag, " beat mv8"}, 64'(mv8), 64'd0);
            tick();
        end
        idx_valid = 1'($urandom); idx = 3'($urandom); idx_last = 1'($urandom);
        check_hold(tag);
        if (!ready_held) begin
            for (int k = 0; k < hold_cycles; k++) begin
                tick();
                idx_valid = 1'($urandom); idx = 3'($urandom); idx_last = 1'($urandom);
                check_hold({tag, " held"});
            end
            mask_ready = 1'b1;
        end
        idx_valid = 1'b0;
        tick();
        mask_ready = 1'b0;
        check_idle(tag);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{3, '{7, 0, 3, 0}, 8'h89, 3, 1'b0, 6'h09, 2, 1'b1, 1'b0};
        vecs[1] = '{1, '{4, 0, 0, 0}, 8'h10, 1, 1'b0, 6'h10, 1, 1'b0, 1'b0};
        vecs[2] = '{2, '{2, 2, 0, 0}, 8'h04, 1, 1'b0, 6'h04, 1, 1'b0, 1'b1};
        vecs[3] = '{2, '{6, 1, 0, 0}, 8'h42, 2, 1'b0, 6'h02, 1, 1'b1, 1'b0};
        vecs[4] = '{1, '{0, 0, 0, 0}, 8'h01, 1, 1'b0, 6'h01, 1, 1'b0, 1'b0};
        vecs[5] = '{1, '{1, 0, 0, 0}, 8'h02, 1, 1'b0, 6'h02, 1, 1'b0, 1'b0};
        vecs[6] = '{1, '{7, 0, 0, 0}, 8'h80, 1, 1'b0, 6'h00, 0, 1'b1, 1'b0};
        vecs[7] = '{4, '{5, 5, 6, 6}, 8'h60, 2, 1'b0, 6'h20, 1, 1'b1, 1'b1};

        rst = 1'b1; idx_valid = 1'b0; idx = 3'd0; idx_last = 1'b0; mask_ready = 1'b0;
        #1;
        check("reset mv8", 64'(mv8), 64'd0);
        check("reset mask8", 64'(mask8), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_idle("post reset");

        // Table: fixed expectations, applied through the same message driver.
        foreach (vecs[v]) begin
            msg_q.delete();
            for (int j = 0; j < vecs[v].n; j++) msg_q.push_back(vecs[v].ids[j]);
            mask_ready = 1'b0;
            for (int j = 0; j < vecs[v].n; j++) begin
                idx_valid = 1'b1; idx = 3'(vecs[v].ids[j]); idx_last = (j == vecs[v].n - 1);
                tick();
            end
            idx_valid = 1'b0;
            check($sformatf("vec%0d mask8", v), 64'(mask8), 64'(vecs[v].m8));
            check($sformatf("vec%0d cnt8", v), 64'(cnt8), 64'(vecs[v].c8));
            check($sformatf("vec%0d oor8", v), 64'(oor8), 64'(vecs[v].o8));
            check($sformatf("vec%0d mask6", v), 64'(mask6), 64'(vecs[v].m6));
            check($sformatf("vec%0d cnt6", v), 64'(cnt6), 64'(vecs[v].c6));
            check($sformatf("vec%0d oor6", v), 64'(oor6), 64'(vecs[v].o6));
`ifdef INDEX_MASK_ACCUMULATOR_DUP_DETECT_EN
            check($sformatf("vec%0d dup8", v), 64'(dup8), 64'(vecs[v].dup));
`else
            check($sformatf("vec%0d dup8", v), 64'(dup8), 64'd0);
`endif
            mask_ready = 1'b1;
            tick();
            mask_ready = 1'b0;
            check_idle($sformatf("vec%0d", v));
        end

        // Result held for 5 cycles while beats keep arriving.
        msg_q.delete(); msg_q.push_back(4);
        run_msg("hold5", 0, 5, 1'b0);

        // Reset mid-message discards the partial mask.
        msg_q.delete();
        idx_valid = 1'b1; idx = 3'd1; idx_last = 1'b0; tick();
        idx = 3'd2; tick();
        idx_valid = 1'b0; rst = 1'b1;
        #1;
        check("midrst rdy8", 64'(rdy8), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        msg_q.push_back(5);
        run_msg("after midrst", 0, 0, 1'b0);

        // Reset during HOLD drops the result.
        msg_q.delete(); msg_q.push_back(3);
        idx_valid = 1'b1; idx = 3'd3; idx_last = 1'b1; tick();
        idx_valid = 1'b0;
        check_hold("pre hold rst");
        rst = 1'b1;
        #1;
        check("holdrst mv8", 64'(mv8), 64'd0);
        check("holdrst mask8", 64'(mask8), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_idle("after holdrst");

        // Back-to-back messages with the consumer always ready.
        msg_q.delete(); msg_q.push_back(0);
        run_msg("b2b0", 0, 0, 1'b1);
        msg_q.delete(); msg_q.push_back(1);
        run_msg("b2b1", 0, 0, 1'b1);

        // Randomized messages against the model.
        for (int r = 0; r < 60; r++) begin
            msg_q.delete();
            repeat ($urandom_range(1, 6)) msg_q.push_back(int'($urandom_range(0, 7)));
            run_msg($sformatf("rand%0d", r), 2, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
